vram_arbiter: RTL and testbench

Arbitrates the single-port video RAM between the VGA scan-out engine and the processor's memory-mapped VRAM region. VGA pixel fetches always win; processor writes are buffered in a small FIFO and drained in idle cycles, mainly horizontal and vertical blanking. Processor reads are served only once buffered writes have drained. The block sits between the processor's MMIO decode, the VGA timing/pixel unit and the VRAM instance inside the top-level wrapper.

---
 rtl/vram_pkg.sv | 9 +
 rtl/vram_wr_fifo.sv | 46 ++++
 rtl/vram_arbiter.sv | 72 +++++++
 tb/tb_vram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry, processor MMIO window and read-FSM state type.
package vram_pkg;
   localparam int VRAM_ADDR_W = 19;
   localparam int VRAM_DATA_W = 8;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam logic [31:0] VRAM_MMIO_BASE = 32'h4000_0000;
   typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: CPU write buffer holding {addr,data} entries until the RAM port is free.
module vram_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int AW = 19,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [AW+DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      wr_d = push_i ? wr_q + PW'(1) : wr_q;
      rd_d = pop_i ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // Storage needs no reset: entries are only visible through a non-zero count.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= {addr_i, data_i};
   end
   assign {addr_o, data_o} = mem_q[rd_q];
   assign full_o = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between VGA scan-out (highest priority),
// buffered CPU writes and CPU reads that wait for the write buffer to drain.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_valid,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   logic fifo_full, fifo_empty, push, pop, issue;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data, rdata_q, rdata_d;
   logic vga_valid_q;
   rd_state_e state_q, state_d;
   vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push_i(push),
      .pop_i(pop),
      .addr_i(cpu_addr),
      .data_i(cpu_wdata),
      .addr_o(head_addr),
      .data_o(head_data),
      .full_o(fifo_full),
      .empty_o(fifo_empty)
   );
   // A read waits while a write is being pushed so it always observes that write.
   always_comb begin
      push = cpu_we && !fifo_full;
      pop = !vga_req && !fifo_empty;
      issue = !vga_req && fifo_empty && !push && state_q == RD_IDLE && cpu_re;
      state_d = issue ? RD_WAIT : RD_IDLE;
      rdata_d = state_q == RD_WAIT ? ram_rdata : rdata_q;
      ram_addr = vga_req ? vga_addr : pop ? head_addr : issue ? cpu_addr : '0;
      ram_we = pop;
      ram_wdata = pop ? head_data : '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RD_IDLE;
         vga_valid_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         vga_valid_q <= vga_req;
         rdata_q <= rdata_d;
      end
   end
   assign cpu_ready = !fifo_full;
   assign vga_data = ram_rdata;
   assign vga_valid = vga_valid_q;
   assign cpu_rvalid = state_q == RD_WAIT;
   assign cpu_rdata = cpu_rvalid ? ram_rdata : rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scenario tasks drive the arbiter against a 1-cycle-latency RAM model;
// expected pixels, writes and read data are queued and matched as the DUT produces them.
module tb_vram_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vga_req = 1'b0, cpu_we = 1'b0, cpu_re = 1'b0;
   logic [AW-1:0] vga_addr = '0, cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] vga_data, cpu_rdata, ram_wdata, ram_rdata;
   logic vga_valid, cpu_ready, cpu_rvalid, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] vga_q[$];
   logic [DW-1:0] rd_q[$];
   logic [AW+DW-1:0] wr_q[$];
   logic [DW-1:0] mv;
   logic [AW+DW-1:0] mw;
   int errors = 0;
   int checks = 0;
   int vcnt = 0;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int a);
      return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (vga_valid) begin
            vcnt++;
            checks++;
            if (vga_q.size() == 0) begin
               errors++;
               $display("FAIL vga_extra: vga_valid with no pending pixel, data=%h", vga_data);
            end else begin
               mv = vga_q.pop_front();
               if (vga_data !== mv) begin
                  errors++;
                  $display("FAIL vga_data: got %h expected %h", vga_data, mv);
               end
            end
         end
         if (ram_we) begin
            checks++;
            if (vga_req !== 1'b0) begin
               errors++;
               $display("FAIL we_during_vga: ram_we=1 while vga_req=1");
            end else if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL ram_write_extra: addr=%0d data=%h, none expected", ram_addr, ram_wdata);
            end else begin
               mw = wr_q.pop_front();
               if ({ram_addr, ram_wdata} !== mw) begin
                  errors++;
                  $display("FAIL ram_write: got addr=%0d data=%h expected addr=%0d data=%h",
                           ram_addr, ram_wdata, mw[AW+DW-1:DW], mw[DW-1:0]);
               end
            end
         end
         if (cpu_rvalid) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rvalid_extra: cpu_rvalid with no pending read, data=%h", cpu_rdata);
            end else begin
               mv = rd_q.pop_front();
               if (cpu_rdata !== mv) begin
                  errors++;
                  $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, mv);
               end
            end
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cpu_ready); end
      if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", ram_we); end
      if (vga_valid !== 1'b0) begin errors++; $display("FAIL rst_vga_valid: got %b expected 0", vga_valid); end
      if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", cpu_rvalid); end
      if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", cpu_rdata); end
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         vga_req = 1'b1; vga_addr = AW'(700 + k); vga_q.push_back(pat(700 + k));
         cpu_we = 1'b1; cpu_addr = AW'(300 + k); cpu_wdata = 8'(8'hE0 + k);
         @(negedge clk);
         checks++;
         if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_buf_ready%0d: got %b expected 1", k, cpu_ready); end
      end
      @(posedge clk); #1;
      cpu_we = 1'b0; vga_req = 1'b0; reset = 1'b1;
      #1;
      checks += 3;
      if (vga_valid !== 1'b0) begin errors++; $display("FAIL async_vga_valid: got %b expected 0", vga_valid); end
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b expected 1", cpu_ready); end
      if (ram_we !== 1'b0) begin errors++; $display("FAIL async_we: got %b expected 0", ram_we); end
      vga_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", cpu_ready); end
      for (int k = 0; k < 3; k++)
         if (ram[300 + k] !== pat(300 + k)) begin
            errors++;
            $display("FAIL rst_discard%0d: ram=%h expected %h", k, ram[300 + k], pat(300 + k));
         end
   endtask

   task automatic test_vga_stream();
      vcnt = 0;
      for (int i = 0; i < 640; i++) begin
         @(posedge clk); #1;
         vga_req = 1'b1; vga_addr = AW'(i); vga_q.push_back(pat(i));
         @(negedge clk);
         checks++;
         if (ram_we !== 1'b0) begin errors++; $display("FAIL stream_we%0d: got %b expected 0", i, ram_we); end
      end
      @(posedge clk); #1 vga_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 2;
      if (vcnt != 640) begin errors++; $display("FAIL stream_count: got %0d expected 640", vcnt); end
      if (vga_q.size() != 0) begin errors++; $display("FAIL stream_left: %0d pixels undelivered", vga_q.size()); end
   endtask

   task automatic test_write_buffer();
      int acc;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         vga_req = 1'b1; vga_addr = AW'(640 + k); vga_q.push_back(pat(640 + k));
         cpu_we = 1'b1;
         cpu_addr = AW'(k < 4 ? 100 + k : 104);
         cpu_wdata = k < 4 ? 8'(8'h11 * (k + 1)) : 8'h55;
         @(negedge clk);
         checks++;
         if (k < 4) begin
            if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wb_ready%0d: got %b expected 1", k, cpu_ready); end
            wr_q.push_back({cpu_addr, cpu_wdata});
         end else if (cpu_ready !== 1'b0) begin
            errors++; $display("FAIL wb_full%0d: cpu_ready got %b expected 0", k, cpu_ready);
         end
      end
      acc = -1;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         vga_req = 1'b0; cpu_we = acc < 0;
         @(negedge clk);
         if (acc < 0 && cpu_ready) begin
            acc = j;
            wr_q.push_back({cpu_addr, cpu_wdata});
         end
      end
      @(posedge clk); #1 cpu_we = 1'b0;
      checks += 7;
      if (acc < 0 || acc > 1) begin errors++; $display("FAIL wb_fifth_accept: blanking cycle %0d expected 0..1", acc); end
      if (wr_q.size() != 0) begin errors++; $display("FAIL wb_drain: %0d writes not committed", wr_q.size()); end
      for (int k = 0; k < 5; k++)
         if (ram[100 + k] !== (k < 4 ? 8'(8'h11 * (k + 1)) : 8'h55)) begin
            errors++; $display("FAIL wb_ram%0d: got %h", k, ram[100 + k]);
         end
   endtask

   task automatic test_read_after_write();
      int lat;
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_addr = AW'(2000); cpu_wdata = 8'hA5;
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL raw_ready: got %b expected 1", cpu_ready); end
      wr_q.push_back({cpu_addr, cpu_wdata});
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_re = 1'b1; rd_q.push_back(8'hA5);
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1) begin errors++; $display("FAIL raw_commit: ram_we got %b expected 1", ram_we); end
      lat = -1;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (cpu_rvalid) lat = k;
      end
      @(posedge clk); #1 cpu_re = 1'b0;
      @(negedge clk);
      checks += 3;
      if (lat != 2) begin errors++; $display("FAIL raw_latency: rvalid %0d cycles after commit, expected 2", lat); end
      if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL raw_pulse: rvalid got %b expected 0", cpu_rvalid); end
      if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL raw_hold: rdata got %h expected a5", cpu_rdata); end
   endtask

   task automatic test_read_blocked();
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         vga_req = 1'b1; vga_addr = AW'(1000 + k); vga_q.push_back(pat(1000 + k));
         cpu_re = 1'b1; cpu_addr = AW'(3000);
         @(negedge clk);
         checks++;
         if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL blk_rvalid%0d: got %b expected 0", k, cpu_rvalid); end
      end
      @(posedge clk); #1;
      vga_req = 1'b0; rd_q.push_back(pat(3000));
      @(negedge clk);
      checks += 2;
      if (ram_addr !== AW'(3000)) begin errors++; $display("FAIL blk_issue_addr: got %0d expected 3000", ram_addr); end
      if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL blk_early: rvalid got %b expected 0", cpu_rvalid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL blk_rvalid12: got %b expected 1", cpu_rvalid); end
      @(posedge clk); #1 cpu_re = 1'b0;
   endtask

   task automatic test_simultaneous();
      int wc, rv;
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = AW'(5); cpu_wdata = 8'hC3;
      @(negedge clk);
      checks += 2;
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b expected 1", cpu_ready); end
      if (ram_addr !== '0 || ram_we !== 1'b0) begin
         errors++; $display("FAIL sim_early_issue: ram_addr=%0d ram_we=%b expected 0/0", ram_addr, ram_we);
      end
      wr_q.push_back({cpu_addr, cpu_wdata});
      rd_q.push_back(8'hC3);
      wc = -1; rv = -1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         cpu_we = 1'b0; cpu_re = rv < 0;
         @(negedge clk);
         if (ram_we && wc < 0) wc = k;
         if (cpu_rvalid && rv < 0) rv = k;
      end
      checks += 2;
      if (wc < 0 || rv < 0) begin errors++; $display("FAIL sim_done: write cycle %0d read cycle %0d", wc, rv); end
      if (rv <= wc) begin errors++; $display("FAIL sim_order: read at %0d not after write at %0d", rv, wc); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = pat(i);
      ram_rdata = '0;
      test_reset();
      test_vga_stream();
      test_write_buffer();
      test_read_after_write();
      test_read_blocked();
      test_simultaneous();
      repeat (3) @(posedge clk);
      #1;
      checks += 3;
      if (vga_q.size() != 0) begin errors++; $display("FAIL end_vga_q: %0d left", vga_q.size()); end
      if (wr_q.size() != 0) begin errors++; $display("FAIL end_wr_q: %0d left", wr_q.size()); end
      if (rd_q.size() != 0) begin errors++; $display("FAIL end_rd_q: %0d left", rd_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
